// File: rtl/vgroup_sequencer_if.sv
// Instruction-in / micro-op-out bundle of the vector group sequencer.
// The slave side is the sequencer; the master side feeds instructions and accepts micro-ops.
interface vgroup_sequencer_if #(
    parameter int REG_IDX_W     = 5,
    parameter int MAX_LMUL_LOG2 = 3,
    parameter int OP_W          = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_instr;
    logic                     uop_valid;
    logic                     uop_ready;
    logic [REG_IDX_W-1:0]     uop_vd;
    logic [REG_IDX_W-1:0]     uop_vs1;
    logic [REG_IDX_W-1:0]     uop_vs2;
    logic [OP_W-1:0]          uop_valu_op;
    logic [1:0]               uop_valu_src;
    logic [MAX_LMUL_LOG2-1:0] uop_idx;
    logic                     uop_last;
    logic                     illegal;
    logic [MAX_LMUL_LOG2-1:0] cur_lmul_log2;

    modport master (
        output in_valid, in_instr, uop_ready,
        input  in_ready, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_valu_op,
               uop_valu_src, uop_idx, uop_last, illegal, cur_lmul_log2
    );

    modport slave (
        input  in_valid, in_instr, uop_ready,
        output in_ready, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_valu_op,
               uop_valu_src, uop_idx, uop_last, illegal, cur_lmul_log2
    );
endinterface

// File: rtl/vgroup_sequencer.sv
// Decode-and-issue stage: decodes OP-V instructions, tracks LMUL from vsetvli and
// expands each grouped arithmetic op into 2^LMUL single-register micro-ops.
module vgroup_sequencer #(
    parameter int NUM_VREGS     = 32,
    parameter int REG_IDX_W     = $clog2(NUM_VREGS),
    parameter int MAX_LMUL_LOG2 = 3,
    parameter int OP_W          = 4
) (
    input logic               clk,
    input logic               rst,
    vgroup_sequencer_if.slave bus
);
    // Shared OP-V encodings (mirrors the project constants header)
    localparam logic [6:0] VR_FORMAT = 7'b1010111;
    localparam logic [2:0] VV_FORMAT = 3'b000;
    localparam logic [2:0] VX_FORMAT = 3'b100;
    localparam logic [2:0] VI_FORMAT = 3'b011;
    localparam logic [2:0] VC_FORMAT = 3'b111;
    localparam logic [5:0] VADD      = 6'b000000;
    localparam logic [5:0] VSUB      = 6'b000010;
    localparam logic [5:0] VMUL      = 6'b100101;
    localparam logic [5:0] VAND      = 6'b001001;
    localparam logic [5:0] VOR       = 6'b001010;
    localparam logic [5:0] VXOR      = 6'b001011;
    localparam logic [1:0] SRC_VV    = 2'b00;
    localparam logic [1:0] SRC_VX    = 2'b01;
    localparam logic [1:0] SRC_VI    = 2'b10;

    typedef enum logic {IDLE, ISSUE} state_t;

    // Returns {known, vector-vector op code}; VX/VI codes are this value + 1.
    function automatic logic [OP_W:0] decode_funct6(input logic [5:0] f6);
        case (f6)
            VADD:    decode_funct6 = {1'b1, OP_W'(4'b0000)};
            VSUB:    decode_funct6 = {1'b1, OP_W'(4'b0010)};
            VMUL:    decode_funct6 = {1'b1, OP_W'(4'b0100)};
            VAND:    decode_funct6 = {1'b1, OP_W'(4'b0110)};
            VOR:     decode_funct6 = {1'b1, OP_W'(4'b1000)};
            VXOR:    decode_funct6 = {1'b1, OP_W'(4'b1010)};
            default: decode_funct6 = '0;
        endcase
    endfunction

    function automatic logic [MAX_LMUL_LOG2-1:0] last_index(input logic [MAX_LMUL_LOG2-1:0] lmul);
        return ~({MAX_LMUL_LOG2{1'b1}} << lmul);
    endfunction

    state_t                   state_q, state_n;
    logic                     vld_q, vld_n;
    logic [REG_IDX_W-1:0]     vd_q, vd_n, vs1_q, vs1_n, vs2_q, vs2_n;
    logic [OP_W-1:0]          op_q, op_n;
    logic [1:0]               src_q, src_n;
    logic [MAX_LMUL_LOG2-1:0] idx_q, idx_n, grp_lmul_q, grp_lmul_n, lmul_q, lmul_n;
    logic                     last_q, last_n, illegal_q, illegal_n;

    logic [6:0]           opcode;
    logic [2:0]           funct3, vlmul;
    logic [5:0]           funct6;
    logic [REG_IDX_W-1:0] f_vd, f_vs1, f_vs2, align_mask;
    logic                 f6_known, is_vv, is_vx, is_vi, is_vc, misaligned;
    logic [OP_W-1:0]      op_vv, op_sel;
    logic [1:0]           src_sel;
    logic                 in_ready, accept;
    logic                 unused_vm;

    assign opcode    = bus.in_instr[6:0];
    assign funct3    = bus.in_instr[14:12];
    assign funct6    = bus.in_instr[31:26];
    assign vlmul     = bus.in_instr[22:20];
    assign f_vd      = REG_IDX_W'(bus.in_instr[11:7]);
    assign f_vs1     = REG_IDX_W'(bus.in_instr[19:15]);
    assign f_vs2     = REG_IDX_W'(bus.in_instr[24:20]);
    assign unused_vm = bus.in_instr[25];

    assign {f6_known, op_vv} = decode_funct6(funct6);
    assign is_vv   = (funct3 == VV_FORMAT);
    assign is_vx   = (funct3 == VX_FORMAT);
    assign is_vi   = (funct3 == VI_FORMAT);
    assign is_vc   = (funct3 == VC_FORMAT);
    assign src_sel = is_vx ? SRC_VX : (is_vi ? SRC_VI : SRC_VV);
    assign op_sel  = is_vv ? op_vv : op_vv + 1'b1;

    // A group must start on a register index that is a multiple of 2^LMUL.
    assign align_mask = ~({REG_IDX_W{1'b1}} << lmul_q);
    assign misaligned = (|(f_vd & align_mask)) || (|(f_vs2 & align_mask)) ||
                        (is_vv && (|(f_vs1 & align_mask)));

    // Ready again in the cycle the last micro-op retires, so groups chain without a bubble.
    assign in_ready = (state_q == IDLE) || (vld_q && bus.uop_ready && last_q);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_n    = state_q;
        vld_n      = vld_q;
        vd_n       = vd_q;
        vs1_n      = vs1_q;
        vs2_n      = vs2_q;
        op_n       = op_q;
        src_n      = src_q;
        idx_n      = idx_q;
        last_n     = last_q;
        grp_lmul_n = grp_lmul_q;
        lmul_n     = lmul_q;
        illegal_n  = 1'b0;

        if (vld_q && bus.uop_ready) begin
            if (last_q) begin
                vld_n   = 1'b0;
                state_n = IDLE;
            end else begin
                idx_n  = idx_q + 1'b1;
                vd_n   = vd_q + 1'b1;
                vs2_n  = vs2_q + 1'b1;
                vs1_n  = (src_q == SRC_VV) ? vs1_q + 1'b1 : vs1_q;
                last_n = (MAX_LMUL_LOG2'(idx_q + 1'b1) == last_index(grp_lmul_q));
            end
        end

        if (accept && (opcode == VR_FORMAT)) begin
            if (is_vc) begin
                if (32'(vlmul) <= MAX_LMUL_LOG2) lmul_n = MAX_LMUL_LOG2'(vlmul);
                else                             illegal_n = 1'b1;
            end else if ((is_vv || is_vx || is_vi) && f6_known && !misaligned) begin
                state_n    = ISSUE;
                vld_n      = 1'b1;
                vd_n       = f_vd;
                vs1_n      = f_vs1;
                vs2_n      = f_vs2;
                op_n       = op_sel;
                src_n      = src_sel;
                idx_n      = '0;
                grp_lmul_n = lmul_q;
                last_n     = (lmul_q == '0);
            end else begin
                illegal_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vld_q      <= 1'b0;
            vd_q       <= '0;
            vs1_q      <= '0;
            vs2_q      <= '0;
            op_q       <= '0;
            src_q      <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            grp_lmul_q <= '0;
            lmul_q     <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            vld_q      <= vld_n;
            vd_q       <= vd_n;
            vs1_q      <= vs1_n;
            vs2_q      <= vs2_n;
            op_q       <= op_n;
            src_q      <= src_n;
            idx_q      <= idx_n;
            last_q     <= last_n;
            grp_lmul_q <= grp_lmul_n;
            lmul_q     <= lmul_n;
            illegal_q  <= illegal_n;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.uop_valid     = vld_q;
    assign bus.uop_vd        = vd_q;
    assign bus.uop_vs1       = vs1_q;
    assign bus.uop_vs2       = vs2_q;
    assign bus.uop_valu_op   = op_q;
    assign bus.uop_valu_src  = src_q;
    assign bus.uop_idx       = idx_q;
    assign bus.uop_last      = last_q;
    assign bus.illegal       = illegal_q;
    assign bus.cur_lmul_log2 = lmul_q;
endmodule

// File: tb/tb_vgroup_sequencer.sv
// Bench for vgroup_sequencer: instruction table plus hand-written stall, reset and
// back-to-back sequences, with a queue of expected micro-ops checked at each handshake.
module tb_vgroup_sequencer;
    localparam logic [6:0] VR    = 7'b1010111;
    localparam logic [2:0] F3_VV = 3'b000;
    localparam logic [2:0] F3_VX = 3'b100;
    localparam logic [2:0] F3_VI = 3'b011;
    localparam logic [2:0] F3_VC = 3'b111;
    localparam logic [5:0] VADD  = 6'b000000;
    localparam logic [5:0] VSUB  = 6'b000010;
    localparam logic [5:0] VMUL  = 6'b100101;
    localparam logic [5:0] VAND  = 6'b001001;
    localparam logic [5:0] VOR   = 6'b001010;
    localparam logic [5:0] VXOR  = 6'b001011;

    typedef struct {
        logic [31:0] instr;
        int          ill;
        int          lmul;
        int          nuops;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vgroup_sequencer_if #(.REG_IDX_W(5), .MAX_LMUL_LOG2(3), .OP_W(4)) bus ();

    vgroup_sequencer #(.NUM_VREGS(32), .REG_IDX_W(5), .MAX_LMUL_LOG2(3), .OP_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          ill_seen = 0;
    int          uop_seen = 0;
    int          model_lmul = 0;
    logic [24:0] exp_q[$];
    vec_t        tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] f6, input int vs2, input int vs1,
                                       input logic [2:0] f3, input int vd);
        return {f6, 1'b1, 5'(vs2), 5'(vs1), f3, 5'(vd), VR};
    endfunction

    function automatic logic [31:0] mkset(input int vl);
        return mk(6'd0, vl, 0, F3_VC, 0);
    endfunction

    // Reference behaviour: updates the modelled LMUL and queues the expected micro-ops.
    function automatic void model_accept(input logic [31:0] ins);
        logic [2:0] f3;
        int vd, vs1, vs2, n, code, src;
        bit vv;
        f3  = ins[14:12];
        vd  = int'(ins[11:7]);
        vs1 = int'(ins[19:15]);
        vs2 = int'(ins[24:20]);
        if (ins[6:0] != VR) return;
        if (f3 == F3_VC) begin
            if (ins[22:20] <= 3'd3) model_lmul = int'(ins[22:20]);
            return;
        end
        case (ins[31:26])
            VADD: code = 0;
            VSUB: code = 2;
            VMUL: code = 4;
            VAND: code = 6;
            VOR:  code = 8;
            VXOR: code = 10;
            default: return;
        endcase
        case (f3)
            F3_VV: src = 0;
            F3_VX: src = 1;
            F3_VI: src = 2;
            default: return;
        endcase
        vv = (src == 0);
        n  = 1 << model_lmul;
        if ((vd % n) != 0 || (vs2 % n) != 0 || (vv && (vs1 % n) != 0)) return;
        for (int k = 0; k < n; k++)
            exp_q.push_back({5'(vd + k), 5'(vv ? vs1 + k : vs1), 5'(vs2 + k),
                             4'(vv ? code : code + 1), 2'(src), 3'(k), (k == n - 1)});
    endfunction

    task automatic send(input logic [31:0] ins);
        int t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            chk("send_timeout", 0, 1);
        end else begin
            model_accept(ins);
            bus.in_valid = 1'b1;
            bus.in_instr = ins;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_instr = '0;
        end
    endtask

    task automatic drain();
        int t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while ((exp_q.size() != 0 || bus.uop_valid) && t < 200);
        chk("drain", (exp_q.size() == 0 && !bus.uop_valid), 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.uop_valid) begin
                chk("in_ready_busy", bus.in_ready, bus.uop_ready && bus.uop_last);
                if (bus.uop_ready) begin
                    uop_seen++;
                    if (exp_q.size() == 0) chk("unexpected_uop", 0, 1);
                    else chk("uop", {bus.uop_vd, bus.uop_vs1, bus.uop_vs2, bus.uop_valu_op,
                                     bus.uop_valu_src, bus.uop_idx, bus.uop_last}, exp_q.pop_front());
                end
            end else begin
                chk("in_ready_idle", bus.in_ready, 1);
            end
            if (bus.illegal) ill_seen++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ill0, u0, t;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.uop_ready = 1'b1;

        tbl.push_back('{mk(VADD, 4, 6, F3_VV, 2),    0, 0, 1, "vadd_vv_m1"});
        tbl.push_back('{mkset(2),                    0, 2, 0, "vset_2"});
        tbl.push_back('{mk(VSUB, 16, 5, F3_VX, 8),   0, 2, 4, "vsub_vx_m4"});
        tbl.push_back('{mk(VXOR, 20, 31, F3_VI, 12), 0, 2, 4, "vxor_vi_m4"});
        tbl.push_back('{mk(VOR, 8, 3, F3_VI, 6),     1, 2, 0, "vor_vi_misaligned_vd"});
        tbl.push_back('{mkset(4),                    1, 2, 0, "vset_too_big"});
        tbl.push_back('{mk(VADD, 8, 2, F3_VV, 4),    1, 2, 0, "vadd_vv_misaligned_vs1"});
        tbl.push_back('{mk(VAND, 8, 3, F3_VX, 4),    0, 2, 4, "vand_vx_raw_rs1"});
        tbl.push_back('{32'h0000_0013,               0, 2, 0, "non_opv_dropped"});
        tbl.push_back('{mk(VADD, 8, 4, 3'b001, 4),   1, 2, 0, "unknown_funct3"});
        tbl.push_back('{mk(6'b111111, 8, 4, F3_VV, 4), 1, 2, 0, "unknown_funct6"});
        tbl.push_back('{mkset(3),                    0, 3, 0, "vset_3"});
        tbl.push_back('{mk(VMUL, 16, 24, F3_VV, 8),  0, 3, 8, "vmul_vv_m8"});
        tbl.push_back('{mk(VOR, 16, 1, F3_VX, 9),    1, 3, 0, "vor_vx_misaligned_m8"});
        tbl.push_back('{mkset(0),                    0, 0, 0, "vset_0"});
        tbl.push_back('{mk(VMUL, 0, 1, F3_VV, 31),   0, 0, 1, "vmul_vv_m1_top"});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_uop_valid", bus.uop_valid, 0);
        chk("rst_illegal", bus.illegal, 0);
        chk("rst_lmul", bus.cur_lmul_log2, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_uop_fields", {bus.uop_vd, bus.uop_vs1, bus.uop_vs2, bus.uop_idx}, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            ill0 = ill_seen;
            u0   = uop_seen;
            send(tbl[i].instr);
            drain();
            chk({tbl[i].name, "_illegal"}, ill_seen - ill0, tbl[i].ill);
            chk({tbl[i].name, "_lmul"}, bus.cur_lmul_log2, tbl[i].lmul);
            chk({tbl[i].name, "_nuops"}, uop_seen - u0, tbl[i].nuops);
        end

        // Stall on uop 0 at LMUL=2: outputs must hold
        send(mkset(1));
        drain();
        bus.uop_ready = 1'b0;
        u0 = uop_seen;
        send(mk(VAND, 8, 12, F3_VV, 4));
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", {bus.uop_valid, bus.uop_vd, bus.uop_vs1, bus.uop_idx}, {1'b1, 5'd4, 5'd12, 3'd0});
        end
        @(posedge clk);
        #1;
        bus.uop_ready = 1'b1;
        drain();
        chk("stall_nuops", uop_seen - u0, 2);

        // Back-to-back groups at LMUL=2: no bubble between them
        u0 = uop_seen;
        send(mk(VADD, 2, 4, F3_VV, 0));
        fork
            send(mk(VSUB, 8, 10, F3_VV, 6));
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("b2b_valid", bus.uop_valid, 1);
                end
            end
        join
        drain();
        chk("b2b_nuops", uop_seen - u0, 4);

        // Reset in the middle of an LMUL=8 group
        send(mkset(3));
        drain();
        send(mk(VADD, 8, 16, F3_VV, 0));
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(bus.uop_valid && bus.uop_idx == 3'd3) && t < 50);
        chk("rst_mid_reached_idx3", bus.uop_idx, 3);
        rst = 1'b1;
        exp_q.delete();
        model_lmul = 0;
        @(posedge clk);
        #1;
        chk("rst_mid_uop_valid", bus.uop_valid, 0);
        chk("rst_mid_lmul", bus.cur_lmul_log2, 0);
        chk("rst_mid_in_ready", bus.in_ready, 1);
        chk("rst_mid_fields", {bus.uop_vd, bus.uop_idx, bus.illegal}, 0);
        @(negedge clk);
        rst = 1'b0;
        u0 = uop_seen;
        send(mk(VXOR, 5, 7, F3_VV, 3));
        drain();
        chk("post_rst_vxor_nuops", uop_seen - u0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
